mult_unit: RTL and testbench

MULT_UNIT -- requirements
Module: mult_unit

---
 rtl/mult_if.sv | 24 ++
 rtl/mult_unit.sv | 136 +++++++++++++
 tb/tb_mult_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_if.sv
// Operand, control and HI/LO result bundle for the iterative 32x32 multiplier.
interface mult_if;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, is_signed, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_unit.sv
// Sequential shift-add MULT/MULTU unit with HI/LO registers (MTHI/MTLO/MFHI/MFLO).
// Define MULT_SIGNED_EN to honour is_signed; otherwise every operation is MULTU.
module mult_unit (
    input  logic clk,
    input  logic rst,
    mult_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [31:0] r_mplr;
    logic [4:0]  r_cnt;
    logic        r_fin;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        w_load;
    logic        w_step;
    logic        w_commit;
    logic        w_mt_ok;

`ifdef MULT_SIGNED_EN
    logic        r_neg;

    function automatic logic [31:0] f_mag(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [63:0] f_neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction
`else
    logic        w_unused_sign;
    assign w_unused_sign = bus.is_signed;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_commit    = 1'b0;
        w_mt_ok     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_mt_ok = 1'b1;
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // The extra cycle after the 32nd step writes the finished accumulator to HI/LO.
                if (r_fin) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_step = 1'b1;
                end
            end
            S_DONE: begin
                w_mt_ok     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_cnt   <= '0;
            r_fin   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
`ifdef MULT_SIGNED_EN
            r_neg   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
`ifdef MULT_SIGNED_EN
                r_mcand <= {32'd0, f_mag(bus.a, bus.is_signed)};
                r_mplr  <= f_mag(bus.b, bus.is_signed);
                r_neg   <= (bus.a[31] ^ bus.b[31]) & bus.is_signed;
`else
                r_mcand <= {32'd0, bus.a};
                r_mplr  <= bus.b;
`endif
                r_acc   <= '0;
                r_cnt   <= '0;
                r_fin   <= 1'b0;
            end
            if (w_step) begin
                if (r_mplr[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand <= r_mcand << 1;
                r_mplr  <= r_mplr >> 1;
                r_cnt   <= r_cnt + 5'd1;
                r_fin   <= (r_cnt == 5'd31);
            end
            // A product overwrites both halves; MTHI/MTLO only land outside RUN.
            if (w_commit) begin
`ifdef MULT_SIGNED_EN
                {r_hi, r_lo} <= r_neg ? f_neg64(r_acc) : r_acc;
`else
                {r_hi, r_lo} <= r_acc;
`endif
                r_fin <= 1'b0;
            end else if (w_mt_ok) begin
                if (bus.hi_we) begin
                    r_hi <= bus.wdata;
                end
                if (bus.lo_we) begin
                    r_lo <= bus.wdata;
                end
            end
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: stimulus pushes expected products, a monitor checks each done pulse.
module tb_mult_unit;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;

    typedef struct {
        logic [63:0] prod;
        int          due;
    } exp_t;

    exp_t q_exp[$];

    mult_if bus();

    mult_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: the architectural product, from plain arithmetic.
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic               s_eff;
`ifdef MULT_SIGNED_EN
        s_eff = s;
`else
        s_eff = s & 1'b0;
`endif
        if (s_eff) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding product and its due cycle.
    logic prev_done;
    initial prev_done = 1'b0;
    always @(negedge clk) begin
        if (prev_done) begin
            check("done_width", 64'(bus.done), 64'd0);
        end
        if (bus.done === 1'b1) begin
            if (q_exp.size() == 0) begin
                check("unexpected_done", 64'(bus.done), 64'd0);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.due));
                check("hi", {32'd0, bus.hi}, {32'd0, e.prod[63:32]});
                check("lo", {32'd0, bus.lo}, {32'd0, e.prod[31:0]});
            end
        end
        prev_done = (bus.done === 1'b1);
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic hw, input logic [31:0] wd);
        exp_t e;
        e.prod = ref_prod(a, b, s);
        e.due  = cyc + 34;
        q_exp.push_back(e);
        bus.start     = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.is_signed = s;
        bus.hi_we     = hw;
        bus.wdata     = wd;
        tick(1);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 80; n++) begin
            tick(1);
            if (bus.busy === 1'b0 && bus.done === 1'b0 && q_exp.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_idle timeout busy=%b pending=%0d", bus.busy, q_exp.size());
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rw;
        cyc           = 0;
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.hi_we     = 1'b0;
        bus.lo_we     = 1'b0;
        bus.wdata     = '0;
        tick(3);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hi", {32'd0, bus.hi}, 64'd0);
        check("rst_lo", {32'd0, bus.lo}, 64'd0);
        rst = 1'b0;
        tick(2);

        // MULTU all-ones, latency through the monitor
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0);
        check("busy_run", 64'(bus.busy), 64'd1);
        wait_idle();

        // MTLO then MFLO; MTHI together with start
        bus.lo_we = 1'b1;
        bus.wdata = 32'h1234;
        tick(1);
        bus.lo_we = 1'b0;
        check("mtlo", {32'd0, bus.lo}, 64'h1234);
        issue(32'd3, 32'd4, 1'b0, 1'b1, 32'hAAAA);
        check("mthi_with_start", {32'd0, bus.hi}, 64'hAAAA);
        tick(10);
        check("hi_hold_run", {32'd0, bus.hi}, 64'hAAAA);
        wait_idle();

        // Second start and MTHI during RUN are ignored
        issue(32'd7, 32'd6, 1'b0, 1'b0, 32'd0);
        tick(4);
        bus.start = 1'b1;
        bus.a     = 32'd2;
        bus.b     = 32'd2;
        tick(1);
        bus.start = 1'b0;
        tick(2);
        bus.hi_we = 1'b1;
        bus.wdata = 32'h5555;
        tick(1);
        bus.hi_we = 1'b0;
        wait_idle();
        check("after_ignored_hi", {32'd0, bus.hi}, 64'd0);
        check("after_ignored_lo", {32'd0, bus.lo}, 64'd42);

        // Signed corner cases (MULTU semantics when the feature is compiled out)
        issue(32'hFFFFFFFD, 32'd5, 1'b1, 1'b0, 32'd0);
        wait_idle();
        issue(32'h80000000, 32'h80000000, 1'b1, 1'b0, 32'd0);
        wait_idle();
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'd0);
        wait_idle();

        // Reset mid-RUN aborts without a done pulse
        issue(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'd0);
        tick(9);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        void'(q_exp.pop_back());
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_hi", {32'd0, bus.hi}, 64'd0);
        check("abort_lo", {32'd0, bus.lo}, 64'd0);
        tick(40);
        check("abort_hi_later", {32'd0, bus.hi}, 64'd0);

        // Randomized operations with ignored strobes during RUN
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 0) ra = 32'h80000000;
            if (i % 7 == 0) rb = 32'hFFFFFFFF;
            issue(ra, rb, 1'($urandom_range(0, 1)), 1'b0, 32'd0);
            tick($urandom_range(1, 30));
            bus.hi_we = 1'($urandom_range(0, 1));
            bus.lo_we = 1'($urandom_range(0, 1));
            bus.wdata = $urandom;
            tick(1);
            bus.hi_we = 1'b0;
            bus.lo_we = 1'b0;
            wait_idle();
            rw = $urandom;
            bus.lo_we = 1'b1;
            bus.wdata = rw;
            tick(1);
            bus.lo_we = 1'b0;
            check("mtlo_rand", {32'd0, bus.lo}, {32'd0, rw});
        end

        check("pending_at_end", 64'(q_exp.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
